dual_port_sync_ram: RTL
=======================

# dual_port_sync_ram

Parametrised true-dual-port synchronous RAM, the next generation of our two-port register-file RAM. It adds a hardware clear sequencer that zeroes the whole array after reset or on request, a defined write-collision policy with a collision flag, and per-port read-valid strobes. It sits between two independent requesters (e.g. CPU datapath and DMA/display port) sharing one storage array on a single clock.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, address width in bits
- ADDR_DEPTH, 1 << ADDR_WIDTH, number of words (derived; not overridden)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous request to re-zero the whole array
- busy  out  1  high while the clear sequencer owns the array
- we1, oe1  in  1 each  port A write enable / read enable
- addra  in  ADDR_WIDTH  port A address
- din_a  in  DATA_WIDTH  port A write data
- dout_a  out  DATA_WIDTH  port A registered read data
- vld_a  out  1  port A read data valid, one-cycle pulse
- we2, oe2  in  1 each  port B write enable / read enable
- addrb  in  ADDR_WIDTH  port B address
- din_b  in  DATA_WIDTH  port B write data
- dout_b  out  DATA_WIDTH  port B registered read data
- vld_b  out  1  port B read data valid, one-cycle pulse
- coll  out  1  one-cycle pulse: both ports wrote the same address

## Operation
- Sequencer states: CLEAR, READY. rst forces CLEAR, counter = 0, busy = 1; dout_a, dout_b, vld_a, vld_b, coll = 0.
- CLEAR: each edge writes 0 to mem[counter], counter increments; at the edge where counter == ADDR_DEPTH-1, go to READY, busy = 0. All port inputs ignored in CLEAR; douts held at 0, vld/coll 0.
- READY: clr = 1 at an edge -> CLEAR, counter = 0, busy = 1; port requests in that same cycle are discarded. clr while already in CLEAR is ignored (counter not restarted).
- Write: we = 1 writes din to mem[addr] at the edge. Write wins over read on the same port: oe ignored when we = 1.
- Write collision: we1 & we2 & addra == addrb -> port A data stored, port B write dropped, coll = 1 for one cycle.
- Read: oe = 1 & we = 0 -> dout <= mem[addr], vld = 1 for one cycle. Otherwise dout <= 0, vld <= 0.
- Cross-port read-during-write to same address: read-first (returns pre-write contents) unless DPRAM_BYPASS_EN.
- Both ports reading the same address: both return the same data, no collision.
- Address wraps naturally (no out-of-range possible since ADDR_DEPTH = 2^ADDR_WIDTH).

## Timing
- Read latency 1 cycle: request sampled at edge N, dout/vld valid after edge N, until edge N+1.
- Write visible to any read sampled at edge N+1 or later.
- Clear duration: exactly ADDR_DEPTH edges after rst deassert (or after the clr edge); busy falls after the final clear edge; first request accepted at the next edge.
- rst asserted mid-clear or mid-access: outputs zeroed immediately (asynchronously), clear restarts from address 0; a write in flight at that edge is not guaranteed.
- coll asserts in the same cycle vld would for a request at that edge (after edge N).

## Configuration
- DPRAM_BYPASS_EN defined: write-first cross-port forwarding; a read on one port to the address the other port writes at the same edge returns the new din. If both ports write that address, the forwarded value is din_a.
- Not defined: read-first; such a read returns the old stored word.
- Same-port behaviour is unaffected by the macro.

## Test plan
- Reset then idle: rst pulse, 16 edges -> busy high for exactly 16 edges; then reading every address returns 8'h00 with vld pulse 1 cycle after each request.
- Write/read both ports: A writes 8'hA5 @3, B writes 8'h3C @7; next cycle A reads 7, B reads 3 -> dout_a = 8'h3C, dout_b = 8'hA5, vld_a = vld_b = 1.
- Collision: A writes 8'h11 @5, B writes 8'h22 @5 same edge -> coll = 1 one cycle; later read @5 = 8'h11.
- Read-during-write: mem[9] = 8'h44; A writes 8'h99 @9 while B reads 9 -> dout_b = 8'h44 without macro, 8'h99 with DPRAM_BYPASS_EN.
- clr: fill several addresses, pulse clr -> busy 16 edges, requests during busy produce vld = 0; all reads then 8'h00.
- Reset mid-clear: assert rst at clear step 6 -> douts 0 immediately, busy remains high for 16 edges after release, array reads all 8'h00.

Source files
------------

// File: rtl/dual_port_sync_ram.sv
// dual_port_sync_ram: true-dual-port RAM with clear sequencer, collision flag and read-valid strobes (DPRAM_BYPASS_EN selects write-first forwarding)
module dual_port_sync_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  we1,
  input  logic                  oe1,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  vld_a,
  input  logic                  we2,
  input  logic                  oe2,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  vld_b,
  output logic                  coll
);
  localparam int ADDR_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  logic [0:0] state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];
  logic act, rd_a, rd_b, hit, wr_b;
  logic [DATA_WIDTH-1:0] q_a, q_b;
  assign busy = state == CLEAR;
  assign act  = state == READY && !clr;
  assign rd_a = act && oe1 && !we1;
  assign rd_b = act && oe2 && !we2;
  assign hit  = we1 && we2 && addra == addrb;
  assign wr_b = we2 && !hit;
`ifdef DPRAM_BYPASS_EN
  assign q_a = (we2 && addrb == addra) ? din_b : mem[addra];
  assign q_b = (we1 && addra == addrb) ? din_a : mem[addrb];
`else
  assign q_a = mem[addra];
  assign q_b = mem[addrb];
`endif
  // clear sequencer: sweep every address once, then hand the array to the ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + ADDR_WIDTH'(1);
      if (cnt == ADDR_WIDTH'(ADDR_DEPTH - 1)) state <= READY;
    end else if (clr) begin
      state <= CLEAR;
      cnt   <= '0;
    end
  end
  // storage: clear writes zero, otherwise port A wins a same-address write collision
  always_ff @(posedge clk) begin
    if (busy) mem[cnt] <= '0;
    else if (act) begin
      if (we1) mem[addra] <= din_a;
      if (wr_b) mem[addrb] <= din_b;
    end
  end
  // registered read data, valid strobes and collision pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_a <= '0;
      dout_b <= '0;
      vld_a  <= 1'b0;
      vld_b  <= 1'b0;
      coll   <= 1'b0;
    end else begin
      dout_a <= rd_a ? q_a : '0;
      dout_b <= rd_b ? q_b : '0;
      vld_a  <= rd_a;
      vld_b  <= rd_b;
      coll   <= act && hit;
    end
  end
endmodule
